// File: rtl/filter_coef_loader.sv
// ---------------------------------------------------------------------------
// filter_coef_loader
//
// Double-buffered 3x3 coefficient bank for matrix_filter. The host fills a
// shadow bank one 8.8 fixed-point coefficient per cycle, then requests a
// commit. The shadow bank is copied into the active bank only while frame_i
// is low (vertical blanking), so the kernel never changes in the middle of a
// frame.
//
// Ports
//   clk_i, reset_n_i      clock, synchronous active-low reset
//   frame_i               1 = active lines, 0 = blanking
//   wr_en_i               shadow write strobe
//   wr_addr_i             shadow index 0..8 -> 00,01,02,10,11,12,20,21,22
//   wr_data_i             coefficient value
//   commit_i              request shadow->active transfer at next blanking
//   coef_00_o..coef_22_o  active coefficients (registered)
//   pending_o             commit requested, not yet applied (FSM state)
//   swap_o                1-cycle pulse: active bank updated on this edge
//   wr_rej_o              1-cycle pulse: write rejected while pending
//   addr_err_o            1-cycle pulse: write to address 9..15 ignored
//   swap_count_o          number of applied commits, wraps silently
//
// Handshake: the host writer has no ready input. A write offered with
// wr_en_i is taken on the edge unless a commit is pending or the address is
// out of range; the outcome is reported one cycle later on wr_rej_o or
// addr_err_o (never both; rejection wins). Nothing is ever stalled.
// ---------------------------------------------------------------------------
module filter_coef_loader #(
    parameter int COEF_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  frame_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [COEF_WIDTH-1:0] wr_data_i,
    input  logic                  commit_i,
    output logic [COEF_WIDTH-1:0] coef_00_o,
    output logic [COEF_WIDTH-1:0] coef_01_o,
    output logic [COEF_WIDTH-1:0] coef_02_o,
    output logic [COEF_WIDTH-1:0] coef_10_o,
    output logic [COEF_WIDTH-1:0] coef_11_o,
    output logic [COEF_WIDTH-1:0] coef_12_o,
    output logic [COEF_WIDTH-1:0] coef_20_o,
    output logic [COEF_WIDTH-1:0] coef_21_o,
    output logic [COEF_WIDTH-1:0] coef_22_o,
    output logic                  pending_o,
    output logic                  swap_o,
    output logic                  wr_rej_o,
    output logic                  addr_err_o,
    output logic [CNT_WIDTH-1:0]  swap_count_o
);

    localparam int NUM_COEF   = 9;
    localparam int CENTER_IDX = 4;
    // 1.0 in 8.8 fixed point: the identity kernel centre tap.
    localparam logic [COEF_WIDTH-1:0] COEF_ONE  = COEF_WIDTH'(256);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_COEF - 1);

    // Two-state commit FSM; the state is visible directly on pending_o.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [COEF_WIDTH-1:0] shadow_q [NUM_COEF];
    logic [COEF_WIDTH-1:0] shadow_d [NUM_COEF];
    logic [COEF_WIDTH-1:0] active_q [NUM_COEF];
    logic [COEF_WIDTH-1:0] active_d [NUM_COEF];

    logic                 swap_q,       swap_d;
    logic                 wr_rej_q,     wr_rej_d;
    logic                 addr_err_q,   addr_err_d;
    logic [CNT_WIDTH-1:0] swap_count_q, swap_count_d;

    logic pending;
    logic apply_swap;
    logic wr_accept;
    logic addr_bad;

    // -----------------------------------------------------------------------
    // FSM process 1: state register (plus all datapath registers)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            swap_q       <= 1'b0;
            wr_rej_q     <= 1'b0;
            addr_err_q   <= 1'b0;
            swap_count_q <= '0;
            for (int i = 0; i < NUM_COEF; i++) begin
                shadow_q[i] <= (i == CENTER_IDX) ? COEF_ONE : '0;
                active_q[i] <= (i == CENTER_IDX) ? COEF_ONE : '0;
            end
        end else begin
            state_q      <= state_d;
            swap_q       <= swap_d;
            wr_rej_q     <= wr_rej_d;
            addr_err_q   <= addr_err_d;
            swap_count_q <= swap_count_d;
            for (int i = 0; i < NUM_COEF; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next state
    // A commit seen while already pending is dropped, including on the edge
    // where the swap itself happens.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (commit_i) state_d = ST_PENDING;
            ST_PENDING: if (!frame_i) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM process 3: outputs / decode of the current state
    // -----------------------------------------------------------------------
    always_comb begin
        pending    = (state_q == ST_PENDING);
        apply_swap = pending && !frame_i;
        addr_bad   = (wr_addr_i > LAST_ADDR);
        // Writes are blocked while pending, so the shadow bank is stable
        // for the whole time a swap can be waiting for blanking.
        wr_accept  = wr_en_i && !pending && !addr_bad;
    end

    // -----------------------------------------------------------------------
    // Datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_COEF; i++) begin
            shadow_d[i] = shadow_q[i];
            if (wr_accept && (wr_addr_i == ADDR_WIDTH'(i))) begin
                shadow_d[i] = wr_data_i;
            end
            active_d[i] = apply_swap ? shadow_q[i] : active_q[i];
        end
        swap_d       = apply_swap;
        wr_rej_d     = wr_en_i && pending;
        addr_err_d   = wr_en_i && !pending && addr_bad;
        swap_count_d = swap_count_q + {{(CNT_WIDTH-1){1'b0}}, apply_swap};
    end

    // -----------------------------------------------------------------------
    // Outputs: all straight from flops
    // -----------------------------------------------------------------------
    assign coef_00_o    = active_q[0];
    assign coef_01_o    = active_q[1];
    assign coef_02_o    = active_q[2];
    assign coef_10_o    = active_q[3];
    assign coef_11_o    = active_q[4];
    assign coef_12_o    = active_q[5];
    assign coef_20_o    = active_q[6];
    assign coef_21_o    = active_q[7];
    assign coef_22_o    = active_q[8];
    assign pending_o    = (state_q == ST_PENDING);
    assign swap_o       = swap_q;
    assign wr_rej_o     = wr_rej_q;
    assign addr_err_o   = addr_err_q;
    assign swap_count_o = swap_count_q;

endmodule

// File: tb/tb_filter_coef_loader.sv
// ---------------------------------------------------------------------------
// tb_filter_coef_loader
//
// Bench for filter_coef_loader: directed vector table, hand-written
// sequences for reset and counter wrap, then random traffic checked each
// cycle against a behavioural model of the coefficient bank.
// ---------------------------------------------------------------------------
module tb_filter_coef_loader;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        frame_in = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        commit = 1'b0;

    logic [15:0] c00, c01, c02, c10, c11, c12, c20, c21, c22;
    logic        pending_o, swap_o, wr_rej_o, addr_err_o;
    logic [7:0]  swap_count_o;
    logic [15:0] dut_coef [9];

    assign dut_coef[0] = c00;
    assign dut_coef[1] = c01;
    assign dut_coef[2] = c02;
    assign dut_coef[3] = c10;
    assign dut_coef[4] = c11;
    assign dut_coef[5] = c12;
    assign dut_coef[6] = c20;
    assign dut_coef[7] = c21;
    assign dut_coef[8] = c22;

    filter_coef_loader #(
        .COEF_WIDTH(16),
        .ADDR_WIDTH(4),
        .CNT_WIDTH (8)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .frame_i     (frame_in),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .commit_i    (commit),
        .coef_00_o   (c00),
        .coef_01_o   (c01),
        .coef_02_o   (c02),
        .coef_10_o   (c10),
        .coef_11_o   (c11),
        .coef_12_o   (c12),
        .coef_20_o   (c20),
        .coef_21_o   (c21),
        .coef_22_o   (c22),
        .pending_o   (pending_o),
        .swap_o      (swap_o),
        .wr_rej_o    (wr_rej_o),
        .addr_err_o  (addr_err_o),
        .swap_count_o(swap_count_o)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // The bank as the host sees it: a shadow array, an active array, one
    // outstanding-commit flag and a commit counter modulo 256.
    logic [15:0] m_shadow [9];
    logic [15:0] m_active [9];
    bit          m_pending, m_swap, m_rej, m_aerr;
    int          m_count;

    task automatic model_step(input bit rst_n, input bit frame, input bit we,
                              input logic [3:0] addr, input logic [15:0] data,
                              input bit cm);
        if (!rst_n) begin
            foreach (m_shadow[k]) begin
                m_shadow[k] = (k == 4) ? 16'h0100 : 16'h0000;
                m_active[k] = m_shadow[k];
            end
            m_pending = 0; m_swap = 0; m_rej = 0; m_aerr = 0; m_count = 0;
        end else begin
            bit was_pending;
            was_pending = m_pending;
            m_rej  = we && was_pending;
            m_aerr = we && !was_pending && (int'(addr) > 8);
            m_swap = was_pending && !frame;
            if (m_swap) begin
                m_active  = m_shadow;
                m_count   = (m_count + 1) % 256;
                m_pending = 0;
            end else if (cm && !was_pending) begin
                m_pending = 1;
            end
            if (we && !was_pending && int'(addr) <= 8) m_shadow[addr] = data;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 9; k++)
            check($sformatf("coef[%0d]", k), 32'(dut_coef[k]), 32'(m_active[k]));
        check("pending",    32'(pending_o),    32'(m_pending));
        check("swap",       32'(swap_o),       32'(m_swap));
        check("wr_rej",     32'(wr_rej_o),     32'(m_rej));
        check("addr_err",   32'(addr_err_o),   32'(m_aerr));
        check("swap_count", 32'(swap_count_o), 32'(m_count));
    endtask

    // ---------------- driver ----------------
    // Drive one cycle of inputs, clock it in, then compare against the model.
    task automatic apply(input bit rst_n, input bit frame, input bit we,
                         input logic [3:0] addr, input logic [15:0] data,
                         input bit cm);
        reset_n  = rst_n;
        frame_in = frame;
        wr_en    = we;
        wr_addr  = addr;
        wr_data  = data;
        commit   = cm;
        @(posedge clk);
        #1;
        model_step(rst_n, frame, we, addr, data, cm);
        compare_all();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          frame;
        bit          we;
        logic [3:0]  addr;
        logic [15:0] data;
        bit          cm;
        bit          e_pend;
        bit          e_swap;
        bit          e_rej;
        bit          e_aerr;
        logic [15:0] e_c00;
        logic [15:0] e_c11;
        int          e_cnt;
    } vec_t;

    function automatic vec_t mk(bit f, bit w, logic [3:0] a, logic [15:0] d, bit c,
                                bit ep, bit es, bit er, bit ea,
                                logic [15:0] c00v, logic [15:0] c11v, int cnt);
        vec_t v;
        v.frame = f; v.we = w; v.addr = a; v.data = d; v.cm = c;
        v.e_pend = ep; v.e_swap = es; v.e_rej = er; v.e_aerr = ea;
        v.e_c00 = c00v; v.e_c11 = c11v; v.e_cnt = cnt;
        return v;
    endfunction

    vec_t vecs [26];

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        // Frame active: load 0x0010..0x0090, commit, try a write while
        // pending, then drop frame to swap.
        for (int k = 0; k < 9; k++)
            vecs[k] = mk(1, 1, 4'(k), 16'(16 * (k + 1)), 0, 0, 0, 0, 0, 16'h0000, 16'h0100, 0);
        vecs[9]  = mk(1, 0, 4'd0,  16'h0000, 1, 1, 0, 0, 0, 16'h0000, 16'h0100, 0);
        vecs[10] = mk(1, 0, 4'd0,  16'h0000, 0, 1, 0, 0, 0, 16'h0000, 16'h0100, 0);
        vecs[11] = mk(1, 1, 4'd4,  16'hFFFF, 0, 1, 0, 1, 0, 16'h0000, 16'h0100, 0);
        vecs[12] = mk(1, 0, 4'd0,  16'h0000, 0, 1, 0, 0, 0, 16'h0000, 16'h0100, 0);
        vecs[13] = mk(0, 0, 4'd0,  16'h0000, 0, 0, 1, 0, 0, 16'h0010, 16'h0050, 1);
        vecs[14] = mk(0, 0, 4'd0,  16'h0000, 0, 0, 0, 0, 0, 16'h0010, 16'h0050, 1);
        // Out-of-range addresses, then a swap that must change nothing.
        vecs[15] = mk(0, 1, 4'd9,  16'h1234, 0, 0, 0, 0, 1, 16'h0010, 16'h0050, 1);
        vecs[16] = mk(0, 1, 4'd15, 16'h5678, 0, 0, 0, 0, 1, 16'h0010, 16'h0050, 1);
        vecs[17] = mk(0, 0, 4'd0,  16'h0000, 1, 1, 0, 0, 0, 16'h0010, 16'h0050, 1);
        vecs[18] = mk(0, 0, 4'd0,  16'h0000, 0, 0, 1, 0, 0, 16'h0010, 16'h0050, 2);
        // Write + commit on the same edge in blanking.
        vecs[19] = mk(0, 1, 4'd0,  16'h0200, 1, 1, 0, 0, 0, 16'h0010, 16'h0050, 2);
        vecs[20] = mk(0, 0, 4'd0,  16'h0000, 0, 0, 1, 0, 0, 16'h0200, 16'h0050, 3);
        vecs[21] = mk(0, 0, 4'd0,  16'h0000, 0, 0, 0, 0, 0, 16'h0200, 16'h0050, 3);
        // Rejection wins over address error; commit on the swap edge dropped.
        vecs[22] = mk(1, 0, 4'd0,  16'h0000, 1, 1, 0, 0, 0, 16'h0200, 16'h0050, 3);
        vecs[23] = mk(1, 1, 4'd12, 16'hABCD, 0, 1, 0, 1, 0, 16'h0200, 16'h0050, 3);
        vecs[24] = mk(0, 0, 4'd0,  16'h0000, 1, 0, 1, 0, 0, 16'h0200, 16'h0050, 4);
        vecs[25] = mk(0, 0, 4'd0,  16'h0000, 0, 0, 0, 0, 0, 16'h0200, 16'h0050, 4);

        // Reset held two cycles.
        apply(0, 0, 0, 4'd0, 16'h0000, 0);
        apply(0, 1, 1, 4'd3, 16'hBEEF, 1);
        for (int k = 0; k < 9; k++)
            check($sformatf("reset coef[%0d]", k), 32'(dut_coef[k]), (k == 4) ? 32'h0100 : 32'h0);
        check("reset pending",  32'(pending_o),    32'h0);
        check("reset swap",     32'(swap_o),       32'h0);
        check("reset wr_rej",   32'(wr_rej_o),     32'h0);
        check("reset addr_err", 32'(addr_err_o),   32'h0);
        check("reset count",    32'(swap_count_o), 32'h0);

        foreach (vecs[i]) begin
            apply(1, vecs[i].frame, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].cm);
            check($sformatf("vec%0d pending", i),  32'(pending_o),    32'(vecs[i].e_pend));
            check($sformatf("vec%0d swap", i),     32'(swap_o),       32'(vecs[i].e_swap));
            check($sformatf("vec%0d wr_rej", i),   32'(wr_rej_o),     32'(vecs[i].e_rej));
            check($sformatf("vec%0d addr_err", i), 32'(addr_err_o),   32'(vecs[i].e_aerr));
            check($sformatf("vec%0d coef_00", i),  32'(c00),          32'(vecs[i].e_c00));
            check($sformatf("vec%0d coef_11", i),  32'(c11),          32'(vecs[i].e_c11));
            check($sformatf("vec%0d count", i),    32'(swap_count_o), 32'(vecs[i].e_cnt));
        end
        for (int k = 1; k < 9; k++)
            check($sformatf("bank coef[%0d]", k), 32'(dut_coef[k]),
                  (k == 4) ? 32'h0050 : 32'(16 * (k + 1)));

        // Reset while a commit is pending in an active frame.
        apply(1, 1, 1, 4'd8, 16'h7777, 1);
        apply(1, 1, 0, 4'd0, 16'h0000, 0);
        check("pre-reset pending", 32'(pending_o), 32'h1);
        apply(0, 1, 1, 4'd2, 16'h3333, 1);
        check("mid reset pending", 32'(pending_o), 32'h0);
        check("mid reset coef_11", 32'(c11),       32'h0100);
        check("mid reset coef_00", 32'(c00),       32'h0000);
        check("mid reset count",   32'(swap_count_o), 32'h0);

        // 256 commits in blanking: counter wraps back to 0.
        for (int n = 0; n < 256; n++) begin
            apply(1, 0, 0, 4'd0, 16'h0000, 1);
            apply(1, 0, 0, 4'd0, 16'h0000, 1);
            if (n == 254) check("count at 255", 32'(swap_count_o), 32'd255);
        end
        check("count wrapped", 32'(swap_count_o), 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit          r_rst, r_frame, r_we, r_cm;
            logic [3:0]  r_addr;
            logic [15:0] r_data;
            r_rst   = ($urandom_range(0, 99) != 0);
            r_frame = ($urandom_range(0, 2) != 0);
            r_we    = ($urandom_range(0, 1) != 0);
            r_addr  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15))
                                                  : 4'($urandom_range(0, 8));
            r_data  = 16'($urandom);
            r_cm    = ($urandom_range(0, 3) == 0);
            apply(r_rst, r_frame, r_we, r_addr, r_data, r_cm);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
